// File: rtl/spi_reg_pkg.sv
// Shared types and helpers for the SPI register-file slave.
package spi_reg_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StCmd,
    StData,
    StDone
  } state_e;

  // Value of the first frame bit that selects a read.
  localparam logic RwRead = 1'b1;

  // Bit counter must reach the longer of the command and the data phase.
  function automatic int unsigned cnt_width(int unsigned addr_w, int unsigned data_w);
    int unsigned longest;
    longest = ((1 + addr_w) > data_w) ? (1 + addr_w) : data_w;
    return $clog2(longest + 1);
  endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchroniser with glitch filter and single-cycle rise/fall pulses.
module spi_sync_edge #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic        RESET_VAL   = 1'b0
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;
  logic                   all_hi;
  logic                   all_lo;

  assign all_hi = &sync_q;
  assign all_lo = ~|sync_q;

  // The level only moves once every stage agrees, so pulses narrower than
  // SYNC_STAGES clocks never reach the edge detector.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= {SYNC_STAGES{RESET_VAL}};
      hist_q <= RESET_VAL;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
      if (all_hi) begin
        hist_q <= 1'b1;
      end else if (all_lo) begin
        hist_q <= 1'b0;
      end
    end
  end

  assign level_o = hist_q;
  assign rise_o  = all_hi & ~hist_q;
  assign fall_o  = all_lo & hist_q;

endmodule

// File: rtl/spi_reg_slave.sv
// 3-wire SPI register-file slave: R/W + address command, DATA_W-bit words,
// optional burst auto-increment and read-only registers fed from ro_d.
module spi_reg_slave
  import spi_reg_pkg::*;
#(
  parameter int unsigned         DATA_W      = 16,
  parameter int unsigned         ADDR_W      = 7,
  parameter int unsigned         NUM_REGS    = 4,
  parameter logic [NUM_REGS-1:0] RO_MASK     = '0,
  parameter int unsigned         SYNC_STAGES = 2,
  parameter bit                  BURST_EN    = 1'b1
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic                         spi_sck,
  input  logic                         spi_cs_n,
  input  logic                         spi_sdi,
  output logic                         spi_sdo,
  output logic                         spi_sdo_oe,
  output logic [NUM_REGS*DATA_W-1:0]   reg_q,
  input  logic [NUM_REGS*DATA_W-1:0]   ro_d,
  output logic                         wr_stb,
  output logic [ADDR_W-1:0]            wr_addr,
  output logic                         rd_stb,
  output logic [ADDR_W-1:0]            rd_addr,
  output logic                         busy
);

  localparam int unsigned CntW = cnt_width(ADDR_W, DATA_W);

  logic sck_rise, sck_fall, sck_lvl;
  logic cs_rise, cs_fall, cs_lvl;
  logic sdi_lvl, sdi_rise, sdi_fall;
  logic unused_edges;

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sck (
    .clk_i(clk), .rst_ni(rstn), .d_i(spi_sck),
    .level_o(sck_lvl), .rise_o(sck_rise), .fall_o(sck_fall)
  );

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_cs (
    .clk_i(clk), .rst_ni(rstn), .d_i(spi_cs_n),
    .level_o(cs_lvl), .rise_o(cs_rise), .fall_o(cs_fall)
  );

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sdi (
    .clk_i(clk), .rst_ni(rstn), .d_i(spi_sdi),
    .level_o(sdi_lvl), .rise_o(sdi_rise), .fall_o(sdi_fall)
  );

  assign unused_edges = ^{sck_lvl, cs_lvl, sdi_rise, sdi_fall};

  state_e              state_q, state_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic                rw_q, rw_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   shift_q, shift_d;
  logic                sdo_q, sdo_d;
  logic                sdo_oe_q, sdo_oe_d;
  logic                wr_stb_q, wr_stb_d;
  logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
  logic                rd_stb_q, rd_stb_d;
  logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d;
  logic [DATA_W-1:0]   regs_q [NUM_REGS];

  logic [ADDR_W-1:0]   ld_addr;
  logic [DATA_W-1:0]   rd_val;
  logic [DATA_W-1:0]   word;
  logic                wr_ok;
  logic                commit;
  logic                load_rd;

  // Address of the next read load: the freshly shifted command address, or
  // the auto-incremented address at a burst word boundary.
  assign ld_addr = (state_q == StCmd) ? ((addr_q << 1) | ADDR_W'(sdi_lvl))
                                      : (addr_q + 1'b1);
  assign word    = {shift_q[DATA_W-2:0], sdi_lvl};

  always_comb begin
    rd_val = '0;
    wr_ok  = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (ld_addr == ADDR_W'(i)) begin
        rd_val = RO_MASK[i] ? ro_d[i*DATA_W +: DATA_W] : regs_q[i];
      end
      if (addr_q == ADDR_W'(i)) begin
        wr_ok = !RO_MASK[i];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rw_d      = rw_q;
    addr_d    = addr_q;
    shift_d   = shift_q;
    sdo_d     = sdo_q;
    sdo_oe_d  = sdo_oe_q;
    wr_stb_d  = 1'b0;
    wr_addr_d = wr_addr_q;
    rd_stb_d  = 1'b0;
    rd_addr_d = rd_addr_q;
    commit    = 1'b0;
    load_rd   = 1'b0;

    if (cs_rise) begin
      state_d  = StIdle;
      cnt_d    = '0;
      sdo_oe_d = 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (cs_fall) begin
            state_d = StCmd;
            cnt_d   = '0;
            addr_d  = '0;
            sdo_d   = 1'b0;
          end
        end
        StCmd: begin
          if (sck_rise) begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == '0) begin
              rw_d = sdi_lvl;
            end else begin
              addr_d = (addr_q << 1) | ADDR_W'(sdi_lvl);
            end
            if (cnt_q == CntW'(ADDR_W)) begin
              state_d = StData;
              cnt_d   = '0;
              load_rd = (rw_q == RwRead);
            end
          end
        end
        StData: begin
          if (sck_rise) begin
            cnt_d = cnt_q + 1'b1;
            if (rw_q != RwRead) begin
              shift_d = word;
            end
            if (cnt_q == CntW'(DATA_W - 1)) begin
              cnt_d  = '0;
              commit = (rw_q != RwRead);
              if (BURST_EN) begin
                addr_d  = addr_q + 1'b1;
                load_rd = (rw_q == RwRead);
              end else begin
                state_d  = StDone;
                sdo_oe_d = 1'b0;
              end
            end
          end else if (sck_fall && (rw_q == RwRead)) begin
            sdo_d    = shift_q[DATA_W-1];
            shift_d  = shift_q << 1;
            sdo_oe_d = 1'b1;
          end
        end
        StDone: begin
        end
        default: state_d = StIdle;
      endcase
    end

    if (load_rd) begin
      shift_d   = rd_val;
      rd_stb_d  = 1'b1;
      rd_addr_d = ld_addr;
    end
    if (commit && wr_ok) begin
      wr_stb_d  = 1'b1;
      wr_addr_d = addr_q;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      rw_q      <= 1'b0;
      addr_q    <= '0;
      shift_q   <= '0;
      sdo_q     <= 1'b0;
      sdo_oe_q  <= 1'b0;
      wr_stb_q  <= 1'b0;
      wr_addr_q <= '0;
      rd_stb_q  <= 1'b0;
      rd_addr_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rw_q      <= rw_d;
      addr_q    <= addr_d;
      shift_q   <= shift_d;
      sdo_q     <= sdo_d;
      sdo_oe_q  <= sdo_oe_d;
      wr_stb_q  <= wr_stb_d;
      wr_addr_q <= wr_addr_d;
      rd_stb_q  <= rd_stb_d;
      rd_addr_q <= rd_addr_d;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (commit && wr_ok && (addr_q == ADDR_W'(i))) begin
          regs_q[i] <= word;
        end
      end
    end
  end

  always_comb begin
    reg_q = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      reg_q[i*DATA_W +: DATA_W] = RO_MASK[i] ? ro_d[i*DATA_W +: DATA_W] : regs_q[i];
    end
  end

  // Output enable drops in the very clock that sees CS deassert.
  assign spi_sdo    = sdo_q;
  assign spi_sdo_oe = sdo_oe_q & ~cs_rise;
  assign wr_stb     = wr_stb_q;
  assign wr_addr    = wr_addr_q;
  assign rd_stb     = rd_stb_q;
  assign rd_addr    = rd_addr_q;
  assign busy       = (state_q != StIdle);

endmodule
